// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART transmitter from LSIO bus stores, with a one-frame-per-byte drain FSM.
// Optional threshold interrupt built when UART_TXQ_IRQ_EN is defined (irq_o tied low otherwise).
module uart_tx_queue #(
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] addr_prev_i,
  input  logic [31:0] wvalue_i,
  output logic [31:0] rvalue_o,
  input  logic [10:0] tx_status_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_send_o,
  output logic        irq_o
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);
  localparam logic [10:0] TX_IDLE = 11'h7FF;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [8:0]    level;
  logic          ovf;
  logic [1:0]    state;
  logic [7:0]    last_byte;
  logic [8:0]    thresh_rd;

  logic [1:0] wsel;
  logic       is_write;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       empty;
  logic       full;
  logic       ovf_clr;

  always_comb begin
    wsel     = addr_i[3:2];
    is_write = enable_i && (wstrb_i != 4'b0000);
    push_req = is_write && (wsel == 2'd0) && wstrb_i[0];
    pop      = (state == S_SEND);
    empty    = (level == 9'd0);
    full     = (level == DEPTH_L);
    // A pop in the same cycle frees the slot the push needs, even when full.
    push_ok  = push_req && (!full || pop);
    ovf_clr  = is_write && (wsel == 2'd1) && wstrb_i[2] && wvalue_i[18];
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wvalue_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ovf       <= 1'b0;
      state     <= S_IDLE;
      last_byte <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_byte <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 9'd1;
        2'b01:   level <= level - 9'd1;
        default: level <= level;
      endcase
      if (push_req && !push_ok) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
      // An incoming push into an empty queue lets SEND start on the very next cycle.
      case (state)
        S_IDLE:  if ((!empty || push_ok) && (tx_status_i == TX_IDLE)) state <= S_SEND;
        S_SEND:  state <= S_HOLD;
        S_HOLD:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tx_send_o = (state == S_SEND);
  assign tx_data_o = (state == S_SEND) ? mem[rd_ptr] : last_byte;

`ifdef UART_TXQ_IRQ_EN
  logic [8:0] thresh;
  logic       irq_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      thresh <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (is_write && (wsel == 2'd2)) begin
        if (wstrb_i[0]) thresh[7:0] <= wvalue_i[7:0];
        if (wstrb_i[1]) thresh[8]   <= wvalue_i[8];
      end
      irq_q <= (level <= thresh);
    end
  end

  assign thresh_rd = thresh;
  assign irq_o     = irq_q;
`else
  assign thresh_rd = '0;
  assign irq_o     = 1'b0;
`endif

  always_comb begin
    rvalue_o = '0;
    case (addr_prev_i[3:2])
      2'd1:    rvalue_o = {13'b0, ovf, full, empty, 7'b0, level};
      2'd2:    rvalue_o = {23'b0, thresh_rd};
      default: rvalue_o = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], addr_prev_i[31:4], addr_prev_i[1:0],
                         wstrb_i, wvalue_i};

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: expected bytes are queued at push time and
// popped by a monitor on every tx_send_o pulse; a small transmitter model drives tx_status_i.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int FRAME = 10;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [3:0]  wstrb_i = 4'b0;
  logic [31:0] addr_i = 32'b0;
  logic [31:0] addr_prev_i;
  logic [31:0] wvalue_i = 32'b0;
  logic [31:0] rvalue_o;
  logic [10:0] tx_status_i;
  logic [7:0]  tx_data_o;
  logic        tx_send_o;
  logic        irq_o;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .wstrb_i     (wstrb_i),
    .addr_i      (addr_i),
    .addr_prev_i (addr_prev_i),
    .wvalue_i    (wvalue_i),
    .rvalue_o    (rvalue_o),
    .tx_status_i (tx_status_i),
    .tx_data_o   (tx_data_o),
    .tx_send_o   (tx_send_o),
    .irq_o       (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Bus side: previous-cycle address register.
  always_ff @(posedge clk_i) addr_prev_i <= addr_i;

  // Transmitter model: busy for FRAME cycles after each load, or forced busy.
  int   busy_cnt;
  logic hold_busy = 1'b0;
  always_ff @(posedge clk_i) begin
    if (tx_send_o)         busy_cnt <= FRAME;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_status_i = (hold_busy || busy_cnt != 0) ? 11'h155 : 11'h7FF;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int sent_cnt = 0;
  int last_send = -1;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Monitor: every send is compared against the scoreboard head.
  initial begin
    logic [10:0] prev_status;
    logic        prev_send;
    logic [7:0]  exp_b;
    prev_status = 11'h0;
    prev_send   = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i && tx_send_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: sent %h, required no send", tx_data_o);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_data", 32'(tx_data_o), 32'(exp_b));
        end
        check("tx_idle_before_send", 32'(prev_status), 32'h7FF);
        check("tx_send_one_cycle", 32'(prev_send), 32'h0);
        if (last_send >= 0) begin
          n_cmp++;
          if (cyc - last_send < FRAME + 1) begin
            n_bad++;
            $display("FAIL send_gap: got %0d cycles, required >= %0d", cyc - last_send, FRAME + 1);
          end
        end
        last_send = cyc;
        sent_cnt++;
      end
`ifndef UART_TXQ_IRQ_EN
      check("irq_tied_low", 32'(irq_o), 32'h0);
`endif
      prev_status = tx_status_i;
      prev_send   = tx_send_o;
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(posedge clk_i); #1;
    enable_i = 1'b1; addr_i = a; wstrb_i = s; wvalue_i = d;
    @(posedge clk_i); #1;
    enable_i = 1'b0; wstrb_i = 4'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk_i); #1;
    enable_i = 1'b1; addr_i = a; wstrb_i = 4'b0;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    @(negedge clk_i);
    d = rvalue_o;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    bus_write(32'h0, 4'b0001, {24'h0, b});
  endtask

  task automatic wait_send(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!tx_send_o && n < 300);
    if (!tx_send_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no tx_send_o in %0d cycles, required a send", name, n);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'h0);
    repeat (FRAME + 4) @(negedge clk_i);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of run, required $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int base;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_tx_send", 32'(tx_send_o), 32'h0);
    check("rst_tx_data", 32'(tx_data_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    rst_i = 1'b0;
    bus_read(32'h4, rd);
    check("rst_status", rd, 32'h0001_0000);
    bus_read(32'hC, rd);
    check("reserved_read", rd, 32'h0);

    // 1: single byte into an idle transmitter
    push(8'h55, 1'b1);
    @(negedge clk_i);
    check("t1_send_next_cycle", 32'(tx_send_o), 32'h1);
    wait_drain("t1_drain");
    bus_read(32'h4, rd);
    check("t1_status_empty", rd, 32'h0001_0000);

    // 2: queue while busy, then release
    hold_busy = 1'b1;
    base = sent_cnt;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    repeat (3) @(negedge clk_i);
    bus_read(32'h4, rd);
    check("t2_status_level3", rd, 32'h0000_0003);
    check("t2_no_send_busy", 32'(sent_cnt - base), 32'h0);
    @(posedge clk_i); #1;
    hold_busy = 1'b0;
    wait_drain("t2_drain");
    check("t2_send_count", 32'(sent_cnt - base), 32'd3);

    // 3: overflow on the 17th push, then W1C of ovf
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i), i < 16);
    bus_read(32'h4, rd);
    check("t3_status_full_ovf", rd, 32'h0006_0010);
    bus_write(32'h4, 4'b0100, 32'h0004_0000);
    bus_read(32'h4, rd);
    check("t3_status_ovf_clr", rd, 32'h0002_0010);

    // 4: push into a full queue during the SEND pop
    @(posedge clk_i); #1;
    hold_busy = 1'b0;
    wait_send("t4_wait_send");
    enable_i = 1'b1; addr_i = 32'h0; wstrb_i = 4'b0001; wvalue_i = 32'hA5;
    exp_q.push_back(8'hA5);
    hold_busy = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0; wstrb_i = 4'b0;
    bus_read(32'h4, rd);
    check("t4_status_full_no_ovf", rd, 32'h0002_0010);
    hold_busy = 1'b0;
    wait_drain("t4_drain");

    // 5: asynchronous reset with level 5 and FSM in HOLD
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'h31 + i), 1'b1);
    @(posedge clk_i); #1;
    hold_busy = 1'b0;
    wait_send("t5_wait_send");
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    exp_q.delete();
    hold_busy = 1'b1;
    #1;
    check("t5_async_tx_send", 32'(tx_send_o), 32'h0);
    check("t5_async_tx_data", 32'(tx_data_o), 32'h0);
    check("t5_async_irq", 32'(irq_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    bus_read(32'h4, rd);
    check("t5_status_after_rst", rd, 32'h0001_0000);
    hold_busy = 1'b0;
    push(8'h77, 1'b1);
    wait_drain("t5_drain_after_rst");

    // 6: threshold interrupt
`ifdef UART_TXQ_IRQ_EN
    bus_write(32'h8, 4'b0011, 32'h2);
    bus_read(32'h8, rd);
    check("t6_thresh_rd", rd, 32'h2);
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i), 1'b1);
    repeat (2) @(negedge clk_i);
    check("t6_irq_level4", 32'(irq_o), 32'h0);
    @(posedge clk_i); #1;
    hold_busy = 1'b0;
    wait_send("t6_send1");
    wait_send("t6_send2");
    @(posedge clk_i);
    @(negedge clk_i);
    check("t6_irq_registered_lag", 32'(irq_o), 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("t6_irq_level2", 32'(irq_o), 32'h1);
    wait_drain("t6_drain");
`else
    bus_write(32'h8, 4'b0011, 32'h2);
    bus_read(32'h8, rd);
    check("t6_thresh_rd_zero", rd, 32'h0);
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i), 1'b1);
    @(posedge clk_i); #1;
    hold_busy = 1'b0;
    wait_drain("t6_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
